// File: rtl/stim_pkg.sv
// Shared types, default constants and arithmetic helpers for the stimulus
// generator / response compactor slice.
package stim_pkg;

  localparam logic [31:0] LCG_A_DEF = 32'h41C64E6D;
  localparam logic [31:0] LCG_C_DEF = 32'h3039;
  localparam logic [31:0] POLY_DEF  = 32'h04C11DB7;

  // Widest response fold32 can compact; narrower callers zero-extend.
  localparam int FOLD_MAX_W = 2048;

  typedef enum logic [1:0] {
    STIM_LCG  = 2'd0,
    STIM_WALK = 2'd1,
    STIM_HOLD = 2'd2,
    STIM_ZERO = 2'd3
  } stim_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stim_state_t;

  function automatic logic [31:0] lcg_step(input logic [31:0] s,
                                           input logic [31:0] a,
                                           input logic [31:0] c);
    return s * a + c;
  endfunction

  // Zero padding above the real width leaves the XOR of the real chunks unchanged.
  function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] d);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < FOLD_MAX_W / 32; k++) begin
      acc = acc ^ d[32*k +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit multiple-input signature register: shifts left with polynomial
// feedback and absorbs the 32-bit fold of a wide response word.
module misr32
  import stim_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter logic [31:0] POLY   = POLY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       state
);

  logic [31:0] state_reg;
  logic [31:0] state_next;

  always_comb begin
    state_next = {state_reg[30:0], 1'b0}
               ^ (state_reg[31] ? POLY : 32'h0)
               ^ fold32(FOLD_MAX_W'(data));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_reg <= '0;
    end else if (enable) begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/stim_lcg_misr.sv
// Run-length controlled stimulus generator (LCG / walking-one / hold / zero)
// with a latency-matched MISR compacting the DUT response.
module stim_lcg_misr
  import stim_pkg::*;
#(
  parameter int          IN_W  = 137,
  parameter int          OUT_W = 159,
  parameter int          LAT   = 1,
  parameter logic [31:0] LCG_A = LCG_A_DEF,
  parameter logic [31:0] LCG_C = LCG_C_DEF,
  parameter logic [31:0] POLY  = POLY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [31:0]      cycles,
  input  logic [1:0]       mode,
  output logic [IN_W-1:0]  in_flat,
  output logic             in_valid,
  input  logic [OUT_W-1:0] out_flat,
  output logic             busy,
  output logic             done,
  output logic [31:0]      cyc_count,
  output logic [31:0]      signature
);

  localparam int NW   = (IN_W + 31) / 32;
  localparam int WI_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  stim_state_t      state_reg, state_next;
  stim_mode_t       mode_reg;
  logic [31:0]      lcg_reg;
  logic [31:0]      cycles_reg;
  logic [31:0]      cyc_count_reg;
  logic [WI_W-1:0]  walk_idx_reg;
  logic [IN_W-1:0]  in_flat_reg;
  logic             in_valid_reg;
  logic [3:0]       drain_cnt_reg;

  logic             accept;
  logic             emit;
  logic             dly_valid;
  logic             misr_en;
  logic [NW:0][31:0] chain;
  logic [IN_W-1:0]  lcg_vec;
  logic [IN_W-1:0]  walk_vec;
  logic [IN_W-1:0]  vec_next;

  // One vector is NW chained LCG steps evaluated combinationally.
  assign chain[0] = lcg_reg;
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_word
      assign chain[gi+1] = lcg_step(chain[gi], LCG_A, LCG_C);
      if (32 * gi + 32 <= IN_W) begin : g_full
        assign lcg_vec[32*gi +: 32] = chain[gi+1];
      end else begin : g_part
        assign lcg_vec[IN_W-1:32*gi] = chain[gi+1][IN_W-32*gi-1:0];
      end
    end

    for (gi = 0; gi < IN_W; gi++) begin : g_walk
      assign walk_vec[gi] = (walk_idx_reg == WI_W'(gi));
    end
  endgenerate

  always_comb begin
    vec_next = '0;
    case (mode_reg)
      STIM_LCG, STIM_HOLD: vec_next = lcg_vec;
      STIM_WALK:           vec_next = walk_vec;
      default:             vec_next = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    emit       = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            accept     = 1'b1;
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          // A zero-length run spends one empty RUN cycle before DONE.
          if (cyc_count_reg == cycles_reg) begin
            state_next = ST_DONE;
          end else begin
            emit = 1'b1;
            if (cyc_count_reg + 32'd1 == cycles_reg) begin
              state_next = (LAT == 0) ? ST_DONE : ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == 4'd0) begin
            state_next = ST_DONE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg      <= STIM_LCG;
      lcg_reg       <= '0;
      cycles_reg    <= '0;
      cyc_count_reg <= '0;
      walk_idx_reg  <= '0;
      in_flat_reg   <= '0;
      in_valid_reg  <= 1'b0;
      drain_cnt_reg <= '0;
    end else begin
      in_valid_reg <= emit;
      if (accept) begin
        mode_reg      <= stim_mode_t'(mode);
        lcg_reg       <= seed;
        cycles_reg    <= cycles;
        cyc_count_reg <= '0;
        walk_idx_reg  <= '0;
      end
      if (emit) begin
        in_flat_reg   <= vec_next;
        cyc_count_reg <= cyc_count_reg + 32'd1;
        drain_cnt_reg <= 4'(LAT - 1);
        // Hold mode never advances the LCG, so the first vector repeats.
        if (mode_reg == STIM_LCG) begin
          lcg_reg <= chain[NW];
        end
        if (mode_reg == STIM_WALK) begin
          walk_idx_reg <= (walk_idx_reg == WI_W'(IN_W - 1)) ? '0 : walk_idx_reg + 1'b1;
        end
      end else if (state_reg == ST_DRAIN) begin
        drain_cnt_reg <= drain_cnt_reg - 4'd1;
      end
    end
  end

  // Delay in_valid by the DUT latency so the MISR sees matching responses.
  generate
    if (LAT == 0) begin : g_nodly
      assign dly_valid = in_valid_reg;
    end else begin : g_dly
      logic [LAT-1:0] dly_reg;
      always_ff @(posedge clk) begin
        if (rst || abort) begin
          dly_reg <= '0;
        end else begin
          dly_reg <= (dly_reg << 1) | LAT'(in_valid_reg);
        end
      end
      assign dly_valid = dly_reg[LAT-1];
    end
  endgenerate

  assign misr_en = dly_valid && !abort;

  misr32 #(
    .DATA_W (OUT_W),
    .POLY   (POLY)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .enable (misr_en),
    .data   (out_flat),
    .state  (signature)
  );

  assign in_flat   = in_flat_reg;
  assign in_valid  = in_valid_reg;
  assign cyc_count = cyc_count_reg;
  assign busy      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_stim_lcg_misr.sv
// Directed bench: three stim_lcg_misr configurations (64-bit loopback LAT=1,
// 5-bit walking-one LAT=0, constant response LAT=2) with hand-computed results.
module tb_stim_lcg_misr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: IN_W=64, OUT_W=64, LAT=1, response looped back from stimulus.
  logic        start_a, abort_a;
  logic [31:0] seed_a, cycles_a;
  logic [1:0]  mode_a;
  logic [63:0] in_flat_a;
  logic        in_valid_a, busy_a, done_a;
  logic [31:0] cyc_count_a, signature_a;

  // Instance W: IN_W=5, OUT_W=8, LAT=0.
  logic        start_w, abort_w;
  logic [31:0] seed_w, cycles_w;
  logic [1:0]  mode_w;
  logic [4:0]  in_flat_w;
  logic        in_valid_w, busy_w, done_w;
  logic [31:0] cyc_count_w, signature_w;

  // Instance S: IN_W=16, OUT_W=40, LAT=2, response tied to 1.
  logic        start_s, abort_s;
  logic [31:0] seed_s, cycles_s;
  logic [1:0]  mode_s;
  logic [15:0] in_flat_s;
  logic        in_valid_s, busy_s, done_s;
  logic [31:0] cyc_count_s, signature_s;

  stim_lcg_misr #(.IN_W(64), .OUT_W(64), .LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .seed(seed_a),
    .cycles(cycles_a), .mode(mode_a), .in_flat(in_flat_a), .in_valid(in_valid_a),
    .out_flat(in_flat_a), .busy(busy_a), .done(done_a), .cyc_count(cyc_count_a),
    .signature(signature_a)
  );

  stim_lcg_misr #(.IN_W(5), .OUT_W(8), .LAT(0)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .abort(abort_w), .seed(seed_w),
    .cycles(cycles_w), .mode(mode_w), .in_flat(in_flat_w), .in_valid(in_valid_w),
    .out_flat({3'b000, in_flat_w}), .busy(busy_w), .done(done_w),
    .cyc_count(cyc_count_w), .signature(signature_w)
  );

  stim_lcg_misr #(.IN_W(16), .OUT_W(40), .LAT(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .seed(seed_s),
    .cycles(cycles_s), .mode(mode_s), .in_flat(in_flat_s), .in_valid(in_valid_s),
    .out_flat(40'd1), .busy(busy_s), .done(done_s), .cyc_count(cyc_count_s),
    .signature(signature_s)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] vecs_a[$];
  logic [4:0]  vecs_w[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job on instance A; optionally pokes start mid-run at edge poke_at.
  task automatic run_a(input logic [31:0] sd, input logic [31:0] cy, input logic [1:0] md,
                       input int poke_at, output int edges, output int vcnt);
    seed_a   = sd;
    cycles_a = cy;
    mode_a   = md;
    start_a  = 1'b1;
    vcnt     = 0;
    vecs_a.delete();
    tick();
    edges   = 1;
    start_a = 1'b0;
    while (!done_a && edges < 200) begin
      if (edges == poke_at) begin
        start_a  = 1'b1;
        seed_a   = 32'hFFFF;
        cycles_a = 32'd50;
      end else begin
        start_a = 1'b0;
      end
      tick();
      edges++;
      if (in_valid_a) begin
        vcnt++;
        vecs_a.push_back(in_flat_a);
      end
    end
    start_a = 1'b0;
    check("a_done_reached", 64'(done_a), 64'd1);
    $display("run a: mode=%0d cycles=%0d edges=%0d vectors=%0d", md, cy, edges, vcnt);
  endtask

  localparam logic [63:0] FIRST_VEC = 64'hD3DC167E_00003039;

  initial begin
    int edges;
    int vcnt;
    logic [63:0] first;
    logic [4:0] exp_w [7];
    exp_w = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02};

    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; seed_a = '0; cycles_a = '0; mode_a = '0;
    start_w = 1'b0; abort_w = 1'b0; seed_w = '0; cycles_w = '0; mode_w = '0;
    start_s = 1'b0; abort_s = 1'b0; seed_s = '0; cycles_s = '0; mode_s = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_in_flat",   in_flat_a, 64'd0);
    check("rst_in_valid",  64'(in_valid_a), 64'd0);
    check("rst_busy",      64'(busy_a), 64'd0);
    check("rst_done",      64'(done_a), 64'd0);
    check("rst_cyc_count", 64'(cyc_count_a), 64'd0);
    check("rst_signature", 64'(signature_a), 64'd0);

    // Word order, single vector, LAT=1 timing.
    run_a(32'd0, 32'd1, 2'd0, -1, edges, vcnt);
    first = (vecs_a.size() > 0) ? vecs_a[0] : 64'd0;
    check("word_vec",       first, FIRST_VEC);
    check("word_valid_cnt", 64'(vcnt), 64'd1);
    check("word_done_lat",  64'(edges), 64'd3);
    check("word_cyc_count", 64'(cyc_count_a), 64'd1);
    tick();
    check("word_signature", 64'(signature_a), 64'hD3DC2647);
    check("word_done_hold", 64'(done_a), 64'd1);

    // Hold mode with an ignored start pulse in the middle of RUN.
    run_a(32'd0, 32'd4, 2'd2, 2, edges, vcnt);
    check("hold_valid_cnt", 64'(vcnt), 64'd4);
    foreach (vecs_a[i]) check($sformatf("hold_vec%0d", i), vecs_a[i], FIRST_VEC);
    check("hold_cyc_count", 64'(cyc_count_a), 64'd4);
    check("hold_done_lat",  64'(edges), 64'd6);
    tick();
    check("hold_signature", 64'(signature_a), 64'hB6F1B731);

    // Zero-length run.
    run_a(32'h1234, 32'd0, 2'd1, -1, edges, vcnt);
    check("zero_done_lat",  64'(edges), 64'd2);
    check("zero_valid_cnt", 64'(vcnt), 64'd0);
    tick();
    check("zero_signature", 64'(signature_a), 64'd0);
    check("zero_cyc_count", 64'(cyc_count_a), 64'd0);

    // Abort after the fifth vector of a 100-vector run.
    seed_a = 32'd5; cycles_a = 32'd100; mode_a = 2'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    edges = 0;
    while (cyc_count_a != 32'd5 && edges < 20) begin
      tick();
      edges++;
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    $display("abort a: after %0d vectors", cyc_count_a);
    check("abort_busy",      64'(busy_a), 64'd0);
    check("abort_done",      64'(done_a), 64'd0);
    check("abort_in_valid",  64'(in_valid_a), 64'd0);
    check("abort_cyc_count", 64'(cyc_count_a), 64'd5);

    // Reset in the middle of a run.
    seed_a = 32'd7; cycles_a = 32'd100; mode_a = 2'd0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    $display("reset a: mid-run");
    check("mrst_in_flat",   in_flat_a, 64'd0);
    check("mrst_in_valid",  64'(in_valid_a), 64'd0);
    check("mrst_busy",      64'(busy_a), 64'd0);
    check("mrst_done",      64'(done_a), 64'd0);
    check("mrst_cyc_count", 64'(cyc_count_a), 64'd0);
    check("mrst_signature", 64'(signature_a), 64'd0);
    rst = 1'b0;
    tick();

    // Walking-one on a 5-bit vector, LAT=0.
    seed_w = 32'hABCD; cycles_w = 32'd7; mode_w = 2'd1; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    edges = 1;
    while (!done_w && edges < 200) begin
      tick();
      edges++;
      if (in_valid_w) vecs_w.push_back(in_flat_w);
    end
    $display("run w: mode=1 cycles=7 edges=%0d vectors=%0d", edges, vecs_w.size());
    check("walk_done_lat", 64'(edges), 64'd8);
    check("walk_vec_cnt",  64'(vecs_w.size()), 64'd7);
    foreach (vecs_w[i]) begin
      if (i < 7) check($sformatf("walk_vec%0d", i), 64'(vecs_w[i]), 64'(exp_w[i]));
    end
    check("walk_cyc_count", 64'(cyc_count_w), 64'd7);
    tick();
    check("walk_signature", 64'(signature_w), 64'h40);
    check("walk_busy",      64'(busy_w), 64'd0);

    // Known signature: all-zero stimulus, response tied to 1, LAT=2.
    seed_s = 32'h1; cycles_s = 32'd3; mode_s = 2'd3; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    edges = 1;
    vcnt  = 0;
    while (!done_s && edges < 200) begin
      tick();
      edges++;
      if (in_valid_s) vcnt++;
    end
    $display("run s: mode=3 cycles=3 edges=%0d vectors=%0d", edges, vcnt);
    check("sig_done_lat",  64'(edges), 64'd6);
    check("sig_valid_cnt", 64'(vcnt), 64'd3);
    check("sig_in_flat",   64'(in_flat_s), 64'd0);
    check("sig_cyc_count", 64'(cyc_count_s), 64'd3);
    check("sig_busy",      64'(busy_s), 64'd0);
    tick();
    check("sig_signature", 64'(signature_s), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stim_lcg_misr.md
Name: stim_lcg_misr

Overview:
- Synthesizable, parametrised stimulus generator and response compactor for fuzz harnesses. It replaces the fixed-width, bench-only LCG driver loop.
- Drives an IN_W-bit flat input vector into a DUT for a programmed number of cycles, in one of four stimulus modes.
- Compacts the DUT's OUT_W-bit flat output into a 32-bit MISR signature.
- Lets long runs be checked by one signature compare instead of per-cycle log diffing.

Parameters:
- IN_W, 137, width of the generated vector driven to the DUT.
- OUT_W, 159, width of the DUT response that is compacted.
- LAT, 1, DUT latency in cycles from in_flat/in_valid to a valid out_flat (0..8).
- LCG_A, 32'h41C64E6D, LCG multiplier.
- LCG_C, 32'h3039, LCG increment.
- POLY, 32'h04C11DB7, MISR feedback polynomial.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a run when in IDLE or DONE.
- abort  in  1  returns to IDLE from any state; done is not set.
- seed  in  32  initial LCG state, sampled on accepted start.
- cycles  in  32  number of vectors to apply, sampled on accepted start.
- mode  in  2  0=LCG random, 1=walking-one, 2=hold-first, 3=all-zero; sampled on accepted start.
- in_flat  out  IN_W  registered stimulus vector to the DUT.
- in_valid  out  1  high on cycles where in_flat carries a counted vector.
- out_flat  in  OUT_W  DUT response.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- cyc_count  out  32  vectors applied in the current or last run.
- signature  out  32  MISR state.

Behaviour:
- Reset: state IDLE; in_flat, in_valid, busy, done, cyc_count, signature all 0; LCG state 0; valid delay line cleared.
- Vector composition:
  - NW = ceil(IN_W/32) chained LCG steps per vector, each s' = s*LCG_A + LCG_C mod 2^32.
  - Step k fills in_flat[32k+31:32k]; the top word is truncated to its low bits.
  - All NW steps complete in one cycle; the final s is carried to the next vector.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch seed, cycles and mode; clear cyc_count and signature; clear done.
  - If cycles==0, go to DONE next cycle with signature 0.
  - Otherwise go to RUN.
- RUN, each cycle:
  - in_flat <= next vector; in_valid <= 1; cyc_count++.
  - The first vector appears on in_flat the cycle after start is accepted.
  - After the cycles-th vector is registered, go to DRAIN.
- Mode rules:
  - mode 0: LCG vectors.
  - mode 1: single 1 at bit index (cyc_count mod IN_W); wraps from IN_W-1 to 0.
  - mode 2: first LCG vector repeated for the whole run.
  - mode 3: all zeros.
- Valid delay line: in_valid is delayed by LAT cycles. On each cycle the delayed valid is high:
  - sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(out_flat).
  - fold = XOR of 32-bit chunks of out_flat, with the top chunk zero-padded.
  - With LAT=0, out_flat is sampled in the same cycle in_valid is high.
- DRAIN: in_valid=0, in_flat holds its last value. Lasts exactly LAT cycles, then DONE. With LAT=0, RUN goes straight to DONE.
- DONE: done=1; signature and cyc_count hold until the next accepted start or rst.
- start while busy: ignored.
- abort: has priority over start. Goes to IDLE, clears in_valid, busy and the delay line. signature and cyc_count hold.
- rst: has priority over everything, at any point including mid-run.
- cycles=32'hFFFFFFFF: legal. The counter uses 32 bits with no wrap before completion.

Decomposition:
- Package stim_pkg: mode enum (STIM_LCG, STIM_WALK, STIM_HOLD, STIM_ZERO); FSM state enum; LCG_A/LCG_C/POLY defaults; function lcg_step(s); function fold32 parameterised by width.
- Sub-module misr32 (enable, data, state) holds the compactor. The generator and FSM stay in stim_lcg_misr.

Test Plan:
- Word order: IN_W=64, seed=0, mode 0, cycles=1 -> first in_flat = 64'hD3DC167E_00003039, in_valid high exactly 1 cycle, done 1+LAT+1 cycles after start, cyc_count=1.
- Walking-one: IN_W=5, mode 1, cycles=7 -> in_flat = 01,02,04,08,10,01,02 (hex); cyc_count=7.
- Zero-length run: cycles=0, any mode -> in_valid never high, done 2 cycles after start, signature=0.
- Known signature: LAT=2, out_flat tied to 1, mode 3, cycles=3 -> exactly 3 MISR updates giving signature = 32'h00000007-equivalent per the update formula (3 shifts with 1 XORed in, no feedback) = 32'h00000007.
- Abort and reset mid-run:
  - abort at cycle 5 of cycles=100 -> IDLE next cycle, done stays 0, cyc_count=5.
  - rst mid-run -> all outputs 0 the next cycle.
  - start during RUN has no effect.
- Hold mode: mode 2, seed=0, IN_W=64, cycles=4 -> in_flat = 64'hD3DC167E_00003039 on all 4 valid cycles.
